// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment scanner: glyph table, blank pattern,
// capture FSM encoding and a one-hot helper.
package seven_segment_pkg;

  typedef enum logic [1:0] {
    ST_SETTLING = 2'd0,
    ST_COUNTING = 2'd1,
    ST_CAPTURED = 2'd2
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Entry n is the active-low {a,b,c,d,e,f,g} pattern that shows hex digit n.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'b0111000, 7'b0110000, 7'b1000010, 7'b1110010,
    7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
    7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
    7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
  };

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

endpackage

// File: rtl/seven_segment_glyph_decode.sv
// Combinational lookup of an active-low segment pattern into a hex nibble,
// flagging table hits and the all-off blank pattern.
module seven_segment_glyph_decode
  import seven_segment_pkg::*;
(
  input  logic [6:0] segment,
  output logic       is_glyph,
  output logic       is_blank,
  output logic [3:0] nibble
);

  logic [15:0] match_s;

  // Table patterns are unique, so OR-encoding the hit index is exact.
  always_comb begin
    match_s = 16'h0000;
    nibble  = 4'h0;
    for (int i = 0; i < 16; i++) begin
      match_s[i] = (segment == GLYPH_TABLE[i]);
      nibble     = nibble | (match_s[i] ? 4'(i) : 4'h0);
    end
    is_glyph = |match_s;
    is_blank = (segment == SEG_BLANK);
  end

endmodule

// File: rtl/seven_segment_scanner_decoder.sv
// Recovers the four hex digits shown on a multiplexed seven-segment display by
// watching its anode and segment drive lines.
module seven_segment_scanner_decoder
  import seven_segment_pkg::*;
#(
  parameter int STABLE_CYCLES = 64,
  parameter int STALE_CYCLES  = 1048576
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [3:0]  anode,
  input  logic [6:0]  segment,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic        update,
  output logic [7:0]  error_count
);

  localparam int STAB_W = $clog2(STABLE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
  localparam int STALE_W = $clog2(STALE_CYCLES + 1);
  localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(STALE_CYCLES);
  localparam logic [STALE_W-1:0] STALE_PRE = STALE_W'(STALE_CYCLES - 1);
  localparam logic [STALE_W-1:0] STALE_ONE = STALE_W'(1);

  logic [10:0]        sync1_r, sync2_r, prev_r;
  scan_state_e        state_r;
  logic [STAB_W-1:0]  stab_cnt_r;
  logic [STALE_W-1:0] stale_cnt_r [4];
  logic [15:0]        digits_r;
  logic [3:0]         valid_r;
  logic               update_r;
  logic [7:0]         error_count_r;

  logic        changed_s, onehot_s, capture_s;
  logic [3:0]  cap_mask_s, stale_expire_s, valid_nxt_s;
  logic [15:0] digits_nxt_s;
  logic [7:0]  err_nxt_s;
  logic        is_glyph_s, is_blank_s;
  logic [3:0]  nibble_s;

  seven_segment_glyph_decode u_decode (
    .segment  (sync2_r[6:0]),
    .is_glyph (is_glyph_s),
    .is_blank (is_blank_s),
    .nibble   (nibble_s)
  );

  // Two-flop synchroniser on {anode, segment} plus the previous-sample copy.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sync1_r <= 11'd0;
      sync2_r <= 11'd0;
      prev_r  <= 11'd0;
    end else begin
      sync1_r <= {anode, segment};
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Capture fires once, on the cycle the stability count completes.
  always_comb begin
    changed_s  = (sync2_r != prev_r);
    onehot_s   = is_onehot4(sync2_r[10:7]);
    capture_s  = !changed_s && onehot_s && (state_r != ST_CAPTURED) && (stab_cnt_r == STAB_LAST);
    cap_mask_s = capture_s ? sync2_r[10:7] : 4'b0000;
    for (int i = 0; i < 4; i++) begin
      stale_expire_s[i] = (stale_cnt_r[i] == STALE_PRE);
    end
  end

  // Stability FSM; a non-one-hot anode freezes the count instead of advancing it.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_r    <= ST_SETTLING;
      stab_cnt_r <= '0;
    end else if (changed_s) begin
      state_r    <= ST_SETTLING;
      stab_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_SETTLING, ST_COUNTING: begin
          if (!onehot_s) begin
            state_r <= state_r;
          end else if (stab_cnt_r == STAB_LAST) begin
            state_r <= ST_CAPTURED;
          end else begin
            state_r    <= ST_COUNTING;
            stab_cnt_r <= stab_cnt_r + STAB_ONE;
          end
        end
        ST_CAPTURED: state_r <= ST_CAPTURED;
        default: begin
          state_r    <= ST_SETTLING;
          stab_cnt_r <= '0;
        end
      endcase
    end
  end

  // Next display state; a capture on a digit takes priority over its stale expiry.
  always_comb begin
    digits_nxt_s = digits_r;
    valid_nxt_s  = valid_r;
    for (int i = 0; i < 4; i++) begin
      if (cap_mask_s[i]) begin
        if (is_glyph_s) begin
          digits_nxt_s[4*i +: 4] = nibble_s;
          valid_nxt_s[i]         = 1'b1;
        end else begin
          valid_nxt_s[i] = 1'b0;
        end
      end else if (stale_expire_s[i]) begin
        valid_nxt_s[i] = 1'b0;
      end else begin
        valid_nxt_s[i] = valid_r[i];
      end
    end
    if (capture_s && !is_glyph_s && !is_blank_s && (error_count_r != 8'hFF)) begin
      err_nxt_s = error_count_r + 8'd1;
    end else begin
      err_nxt_s = error_count_r;
    end
  end

  // Per-digit stale counters saturate at the limit until the next capture.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) stale_cnt_r[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cap_mask_s[i]) begin
          stale_cnt_r[i] <= '0;
        end else if (stale_cnt_r[i] != STALE_MAX) begin
          stale_cnt_r[i] <= stale_cnt_r[i] + STALE_ONE;
        end else begin
          stale_cnt_r[i] <= stale_cnt_r[i];
        end
      end
    end
  end

  // Registered outputs and the change pulse.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      digits_r      <= 16'h0000;
      valid_r       <= 4'b0000;
      update_r      <= 1'b0;
      error_count_r <= 8'd0;
    end else begin
      digits_r      <= digits_nxt_s;
      valid_r       <= valid_nxt_s;
      update_r      <= (digits_nxt_s != digits_r) || (valid_nxt_s != valid_r);
      error_count_r <= err_nxt_s;
    end
  end

  assign digits      = digits_r;
  assign digit_valid = valid_r;
  assign update      = update_r;
  assign error_count = error_count_r;

endmodule

// File: doc/seven_segment_scanner_decoder.md
SEVEN_SEGMENT_SCANNER_DECODER -- requirements
Module: seven_segment_scanner_decoder

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 64, giving the consecutive identical samples required before capture (legal range 2..4095).
REQ-002 The block SHALL have parameter STALE_CYCLES, default 1048576, giving the cycles without a capture on a digit before that digit is invalidated.
REQ-003 Port CLK  input  1  sole clock.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port anode  input  4  digit enables, active-high; bit0 is the least significant digit, bit3 the most significant.
REQ-006 Port segment  input  7  {a,b,c,d,e,f,g}, active-low (0 = lit).
REQ-007 Port digits  output  16  decoded nibbles; digit i occupies bits [4i+3:4i].
REQ-008 Port digit_valid  output  4  bit i high when digits[4i+3:4i] holds a currently displayed glyph.
REQ-009 Port update  output  1  one-cycle pulse when any digits or digit_valid bit changes.
REQ-010 Port error_count  output  8  count of unrecognised non-blank glyphs; saturates at 255.

Function
REQ-011 anode and segment SHALL pass through a two-flop synchroniser before any other use.
REQ-012 The FSM SHALL have three states:
- SETTLING: synchronised {anode,segment} differs from the previous sample; stability counter = 0.
- COUNTING: sample unchanged; counter increments each cycle.
- CAPTURED: entered when the counter reaches STABLE_CYCLES-1; capture performed once; held until the sample changes, then back to SETTLING.
REQ-013 A change on any synchronised bit in any state SHALL return the FSM to SETTLING with the counter cleared; no partial capture.
REQ-014 Capture SHALL occur only when exactly one anode bit is set; zero or multiple anode bits give no capture, no error and no counter change.
REQ-015 Glyph table (segment -> nibble):
- 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7
- 0000000=8, 0000100=9, 0001000=A, 1100000=b, 1110010=c, 1000010=d, 0110000=E, 0111000=F
REQ-016 Capture of a table glyph on digit i SHALL load the nibble and set digit_valid[i].
REQ-017 Capture of blank (1111111) on digit i SHALL clear digit_valid[i], leave the nibble unchanged and leave error_count unchanged.
REQ-018 Capture of any other pattern on digit i SHALL clear digit_valid[i] and increment error_count, saturating at 255.
REQ-019 update SHALL pulse in the cycle after a capture only if digits or digit_valid changed; recapturing an identical glyph gives no pulse.
REQ-020 Latency: an input change held stable SHALL appear on the outputs exactly STABLE_CYCLES+3 CLK edges after the first edge that samples it.
REQ-021 Each digit SHALL have its own stale counter, cleared by a capture on that digit (including blank or error).
- On reaching STALE_CYCLES, digit_valid[i] clears and update pulses if the bit was set.
- The counter then holds until the next capture on that digit.
REQ-022 When a capture and a stale expiry hit the same digit in the same cycle, the capture SHALL win.

Reset
REQ-023 Reset SHALL clear, asynchronously, all synchroniser flops, the FSM (to SETTLING), the stability counter and the stale counters.
REQ-024 Reset SHALL force digits=16'h0000, digit_valid=4'b0000, update=0 and error_count=0.
REQ-025 Reset asserted mid-count SHALL abandon any pending capture.
REQ-026 After reset release, the first capture SHALL require a full STABLE_CYCLES+3 cycles.

Structure
REQ-027 The glyph table constants, blank pattern, and FSM state encodings SHALL live in a shared package (seven_segment_pkg) reused by the driver blocks.
REQ-028 Glyph lookup SHALL be the combinational sub-module seven_segment_glyph_decode, mapping segment[6:0] to {is_glyph, is_blank, nibble[3:0]}.

Verification
REQ-029 Directed scenarios (STABLE_CYCLES=8, STALE_CYCLES=1000):
- Scenario 1: anode=0001, segment=0000110 held for 20 cycles -> digits[3:0]=3 and digit_valid=0001; update pulses once, 11 edges after the first sampling edge.
- Scenario 2: scan the four digits with 2,0,1,8, 50 cycles each, anodes switched before segments (one segment per 4 cycles) -> final digits=16'h8102, valid=1111, error_count=0; no transient glyph captured.
- Scenario 3: anode=0100, segment=1111110 held 20 cycles -> error_count=1, digit_valid[2]=0; repeat 300 times -> error_count=255.
- Scenario 4: anode=0011 with a valid glyph, then anode=0000 -> no capture, no update, outputs unchanged.
- Scenario 5: capture 'F' on digit 3, then stop scanning digit 3 for 1000 cycles -> digit_valid[3] clears with one update pulse; digits[15:12] still F.
- Scenario 6: assert reset at counter=5 of a pending capture -> all outputs zero immediately; no update after release.
